// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RV32 control unit: fetch/decode/execute sequencer with bus, IRQ and trap handling.
// Ports: Clk/Rst_n; M_wb_* bus master; Irq/Irq_ack/Epc; Fault; regfile ids/data; ALU control.
module mc_ctrl_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned IRQ_VEC     = 'h10,
  parameter int unsigned BUS_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic [ADDR_W-1:0] M_wb_addr,
  output logic              M_wb_cs,
  output logic              M_wb_we,
  output logic [3:0]        M_wb_sel,
  output logic [31:0]       M_wb_wdata,
  input  logic [31:0]       M_wb_rdata,
  input  logic              M_wb_ack,
  input  logic              Irq,
  output logic              Irq_ack,
  output logic [ADDR_W-1:0] Epc,
  output logic              Fault,
  output logic [4:0]        Rs1_id,
  output logic [4:0]        Rs2_id,
  output logic [4:0]        Rd_id,
  input  logic [31:0]       Rs1_data,
  input  logic [31:0]       Rs2_data,
  output logic [31:0]       Rd_data,
  output logic              Rd_write,
  output logic [3:0]        Alu_control,
  output logic              Alu_enable,
  input  logic              Alu_zero,
  output logic [11:0]       Imm_data,
  output logic              Imm_enable
);

  localparam int I_IDLE = 0;
  localparam int I_FETCH = 1;
  localparam int I_DEC = 2;
  localparam int I_R = 3;
  localparam int I_I = 4;
  localparam int I_L = 5;
  localparam int I_S = 6;
  localparam int I_J = 7;
  localparam int I_B = 8;
  localparam int I_IRQ = 9;
  localparam int I_TRAP = 10;

  typedef enum logic [10:0] {
    S_IDLE  = 11'b00000000001,
    S_FETCH = 11'b00000000010,
    S_DEC   = 11'b00000000100,
    S_EXEC_R = 11'b00000001000,
    S_EXEC_I = 11'b00000010000,
    S_EXEC_L = 11'b00000100000,
    S_EXEC_S = 11'b00001000000,
    S_EXEC_J = 11'b00010000000,
    S_EXEC_B = 11'b00100000000,
    S_IRQ   = 11'b01000000000,
    S_TRAP  = 11'b10000000000
  } state_t;

  localparam logic [ADDR_W-1:0] PC_RST = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_IRQ = IRQ_VEC[ADDR_W-1:0];
  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] epc, epc_n;
  logic [31:0] instr;
  logic [7:0] cnt;
  logic fault;
  logic irq_blk;
  logic bus_wait;

  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] pc32, pc4_32, pcb_32, pcj_32;
  logic [31:0] ea32, jal_rd;
  logic [1:0] lane;
  logic mis, is_st;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data, st_data;
  logic [3:0] st_sel;
  logic boundary;
  logic [ADDR_W-1:0] npc;

  assign f3 = instr[14:12];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  always_comb begin
    pc32 = '0;
    pc32[ADDR_W-1:0] = pc;
  end

  assign pc4_32 = pc32 + 32'd4;
  assign pcb_32 = pc32 + imm_b;
  assign pcj_32 = pc32 + imm_j;

  always_comb begin
    jal_rd = '0;
    jal_rd[ADDR_W-1:0] = pc4_32[ADDR_W-1:0];
  end

  assign is_st = state[I_S];
  assign ea32 = Rs1_data + (is_st ? imm_s : imm_i);
  assign lane = ea32[1:0];

  // Loads allow 0/1/2/4/5, stores only 0/1/2.
  always_comb begin
    mis = 1'b1;
    case (f3)
      3'd0: mis = 1'b0;
      3'd1: mis = lane[0];
      3'd2: mis = |lane;
      3'd4: mis = is_st;
      3'd5: mis = lane[0] | is_st;
      default: mis = 1'b1;
    endcase
  end

  always_comb begin
    ld_b = M_wb_rdata[31:24];
    case (lane)
      2'd0: ld_b = M_wb_rdata[7:0];
      2'd1: ld_b = M_wb_rdata[15:8];
      2'd2: ld_b = M_wb_rdata[23:16];
      default: ld_b = M_wb_rdata[31:24];
    endcase
  end

  assign ld_h = lane[1] ? M_wb_rdata[31:16] : M_wb_rdata[15:0];

  always_comb begin
    ld_data = '0;
    case (f3)
      3'd0: ld_data = {{24{ld_b[7]}}, ld_b};
      3'd1: ld_data = {{16{ld_h[15]}}, ld_h};
      3'd2: ld_data = M_wb_rdata;
      3'd4: ld_data = {24'd0, ld_b};
      3'd5: ld_data = {16'd0, ld_h};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    st_sel = 4'hF;
    st_data = Rs2_data;
    case (f3)
      3'd0: begin
        st_sel = 4'b0001 << lane;
        st_data = {4{Rs2_data[7:0]}};
      end
      3'd1: begin
        st_sel = 4'b0011 << lane;
        st_data = {2{Rs2_data[15:0]}};
      end
      default: begin
        st_sel = 4'hF;
        st_data = Rs2_data;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n = pc;
    epc_n = epc;
    boundary = 1'b0;
    bus_wait = 1'b0;
    npc = pc4_32[ADDR_W-1:0];
    M_wb_addr = '0;
    M_wb_cs = 1'b0;
    M_wb_we = 1'b0;
    M_wb_sel = 4'h0;
    M_wb_wdata = '0;
    Irq_ack = 1'b0;
    Rs1_id = '0;
    Rs2_id = '0;
    Rd_id = '0;
    Rd_data = '0;
    Rd_write = 1'b0;
    Alu_control = '0;
    Alu_enable = 1'b0;
    Imm_data = '0;
    Imm_enable = 1'b0;
    unique case (1'b1)
      state[I_IDLE]: state_n = S_FETCH;
      state[I_FETCH]: begin
        bus_wait = 1'b1;
        M_wb_cs = 1'b1;
        M_wb_sel = 4'hF;
        M_wb_addr = pc;
        if (M_wb_ack) state_n = S_DEC;
      end
      state[I_DEC]: begin
        case (instr[6:0])
          7'b0110011: state_n = S_EXEC_R;
          7'b0010011: state_n = S_EXEC_I;
          7'b0000011: state_n = S_EXEC_L;
          7'b0100011: state_n = S_EXEC_S;
          7'b1101111: state_n = S_EXEC_J;
          7'b1100011: state_n = S_EXEC_B;
          default: boundary = 1'b1;
        endcase
      end
      state[I_R]: begin
        Rs1_id = instr[19:15];
        Rs2_id = instr[24:20];
        Rd_id = instr[11:7];
        Alu_control = {instr[30], f3};
        Alu_enable = 1'b1;
        Rd_write = 1'b1;
        boundary = 1'b1;
      end
      state[I_I]: begin
        Rs1_id = instr[19:15];
        Rd_id = instr[11:7];
        Alu_control = {(f3 == 3'd5) & instr[30], f3};
        Alu_enable = 1'b1;
        Rd_write = 1'b1;
        Imm_data = instr[31:20];
        Imm_enable = 1'b1;
        boundary = 1'b1;
      end
      state[I_L], state[I_S]: begin
        Rs1_id = instr[19:15];
        Rs2_id = is_st ? instr[24:20] : 5'd0;
        Rd_id = is_st ? 5'd0 : instr[11:7];
        if (mis) begin
          state_n = S_TRAP;
        end else begin
          bus_wait = 1'b1;
          M_wb_cs = 1'b1;
          M_wb_we = is_st;
          M_wb_sel = is_st ? st_sel : 4'hF;
          M_wb_wdata = is_st ? st_data : 32'd0;
          M_wb_addr = {ea32[ADDR_W-1:2], 2'b00};
          if (M_wb_ack) begin
            Rd_write = ~is_st;
            Rd_data = is_st ? 32'd0 : ld_data;
            boundary = 1'b1;
          end
        end
      end
      state[I_J]: begin
        Rd_id = instr[11:7];
        Rd_data = jal_rd;
        Rd_write = 1'b1;
        npc = pcj_32[ADDR_W-1:0];
        boundary = 1'b1;
      end
      state[I_B]: begin
        Rs1_id = instr[19:15];
        Rs2_id = instr[24:20];
        if (f3 == 3'd0 || f3 == 3'd1) begin
          Alu_control = 4'b1000;
          Alu_enable = 1'b1;
          if (Alu_zero ^ f3[0]) npc = pcb_32[ADDR_W-1:0];
          boundary = 1'b1;
        end else begin
          state_n = S_TRAP;
        end
      end
      state[I_IRQ]: begin
        Irq_ack = 1'b1;
        state_n = S_FETCH;
      end
      state[I_TRAP]: state_n = S_TRAP;
      default: state_n = S_IDLE;
    endcase
    // Wait budget exhausted without ack: abandon the transfer.
    if (bus_wait && !M_wb_ack && cnt == TO_LAST) state_n = S_TRAP;
    if (boundary) begin
      if (Irq && !irq_blk) begin
        state_n = S_IRQ;
        epc_n = npc;
        pc_n = PC_IRQ;
      end else begin
        state_n = S_FETCH;
        pc_n = npc;
      end
    end
  end

  assign Epc = epc;
  assign Fault = fault;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      pc <= PC_RST;
      epc <= '0;
      fault <= 1'b0;
      instr <= '0;
      cnt <= '0;
      irq_blk <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      epc <= epc_n;
      if (state_n == S_TRAP) fault <= 1'b1;
      if (state[I_FETCH] && M_wb_ack) instr <= M_wb_rdata;
      cnt <= (bus_wait && state_n == state) ? cnt + 8'd1 : 8'd0;
      if (state[I_IRQ]) irq_blk <= 1'b1;
      else if (state[I_FETCH] && M_wb_ack) irq_blk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit.
// Drives bus/regfile responses by hand and checks strobes, PC flow, IRQ and traps.
module tb_mc_ctrl_unit;
  logic Clk = 1'b0;
  logic Rst_n;
  logic [31:0] M_wb_addr;
  logic M_wb_cs, M_wb_we;
  logic [3:0] M_wb_sel;
  logic [31:0] M_wb_wdata, M_wb_rdata;
  logic M_wb_ack;
  logic Irq, Irq_ack;
  logic [31:0] Epc;
  logic Fault;
  logic [4:0] Rs1_id, Rs2_id, Rd_id;
  logic [31:0] Rs1_data, Rs2_data, Rd_data;
  logic Rd_write;
  logic [3:0] Alu_control;
  logic Alu_enable, Alu_zero;
  logic [11:0] Imm_data;
  logic Imm_enable;

  int tests = 0;
  int fails = 0;
  int n;

  mc_ctrl_unit dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .M_wb_addr(M_wb_addr), .M_wb_cs(M_wb_cs), .M_wb_we(M_wb_we),
    .M_wb_sel(M_wb_sel), .M_wb_wdata(M_wb_wdata),
    .M_wb_rdata(M_wb_rdata), .M_wb_ack(M_wb_ack),
    .Irq(Irq), .Irq_ack(Irq_ack), .Epc(Epc), .Fault(Fault),
    .Rs1_id(Rs1_id), .Rs2_id(Rs2_id), .Rd_id(Rd_id),
    .Rs1_data(Rs1_data), .Rs2_data(Rs2_data),
    .Rd_data(Rd_data), .Rd_write(Rd_write),
    .Alu_control(Alu_control), .Alu_enable(Alu_enable),
    .Alu_zero(Alu_zero), .Imm_data(Imm_data), .Imm_enable(Imm_enable)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ins);
    int k = 0;
    while (!(M_wb_cs && !M_wb_we) && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("fetch_cs", {31'd0, M_wb_cs}, 32'd1);
    chk("fetch_addr", M_wb_addr, a);
    M_wb_rdata = ins;
    M_wb_ack = 1'b1;
    @(negedge Clk);
    M_wb_ack = 1'b0;
    M_wb_rdata = '0;
  endtask

  initial begin
    Rst_n = 1'b0; M_wb_rdata = '0; M_wb_ack = 1'b0; Irq = 1'b0;
    Rs1_data = '0; Rs2_data = '0; Alu_zero = 1'b0;
    @(negedge Clk);
    chk("rst_cs", {31'd0, M_wb_cs}, 32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_epc", Epc, 32'd0);
    Rst_n = 1'b1;

    // ADDI x1,x0,5
    fetch(32'h0, 32'h00500093);
    @(negedge Clk);
    chk("addi_en", {30'd0, Alu_enable, Imm_enable}, 32'd3);
    chk("addi_imm", {20'd0, Imm_data}, 32'd5);
    chk("addi_rd", {26'd0, Rd_id, Rd_write}, {26'd0, 5'd1, 1'b1});
    chk("addi_ctl", {28'd0, Alu_control}, 32'd0);
    @(negedge Clk);
    chk("addi_1cyc", {30'd0, Alu_enable, Rd_write}, 32'd0);

    // SUB x3,x1,x2
    fetch(32'h4, 32'h402081B3);
    @(negedge Clk);
    chk("sub_ctl", {28'd0, Alu_control}, 32'h8);
    chk("sub_ids", {17'd0, Rs1_id, Rs2_id, Rd_id}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("sub_imm_en", {31'd0, Imm_enable}, 32'd0);

    // ADDI x1,x0,0x400: bit30 must not reach Alu_control
    fetch(32'h8, 32'h40000093);
    @(negedge Clk);
    chk("addi400_ctl", {28'd0, Alu_control}, 32'h0);
    chk("addi400_imm", {20'd0, Imm_data}, 32'h400);

    // SRAI x1,x1,1
    fetch(32'hC, 32'h4010D093);
    @(negedge Clk);
    chk("srai_ctl", {28'd0, Alu_control}, 32'hD);

    // LB x2,1(x0)
    fetch(32'h10, 32'h00100103);
    @(negedge Clk);
    chk("lb_bus", {30'd0, M_wb_cs, M_wb_we}, 32'd2);
    chk("lb_addr", M_wb_addr, 32'h0);
    M_wb_rdata = 32'h0000_8000; M_wb_ack = 1'b1;
    #1;
    chk("lb_rdw", {26'd0, Rd_id, Rd_write}, {26'd0, 5'd2, 1'b1});
    chk("lb_data", Rd_data, 32'hFFFF_FF80);
    @(negedge Clk);
    M_wb_ack = 1'b0;

    // LBU x2,1(x0)
    fetch(32'h14, 32'h00104103);
    @(negedge Clk);
    M_wb_rdata = 32'h0000_8000; M_wb_ack = 1'b1;
    #1;
    chk("lbu_data", Rd_data, 32'h0000_0080);
    @(negedge Clk);
    M_wb_ack = 1'b0;

    // SH x3,2(x0) with one wait cycle
    fetch(32'h18, 32'h00301123);
    Rs2_data = 32'h1234;
    @(negedge Clk);
    chk("sh_bus", {30'd0, M_wb_cs, M_wb_we}, 32'd3);
    chk("sh_sel", {28'd0, M_wb_sel}, 32'hC);
    chk("sh_wdata", M_wb_wdata, 32'h1234_1234);
    chk("sh_rdw", {31'd0, Rd_write}, 32'd0);
    @(negedge Clk);
    chk("sh_hold", {M_wb_addr[30:0], M_wb_cs}, 32'd1);
    M_wb_ack = 1'b1;
    @(negedge Clk);
    M_wb_ack = 1'b0;

    // JAL x1,+4 at 0x1C
    fetch(32'h1C, 32'h004000EF);
    @(negedge Clk);
    chk("jal_rd", Rd_data, 32'h20);
    chk("jal_rdw", {26'd0, Rd_id, Rd_write}, {26'd0, 5'd1, 1'b1});

    // BNE taken, -8 from 0x20
    fetch(32'h20, 32'hFE209CE3);
    Alu_zero = 1'b0;
    @(negedge Clk);
    chk("bne_ctl", {26'd0, Alu_control, Alu_enable, Rd_write},
        {26'd0, 4'b1000, 1'b1, 1'b0});

    // JAL x0,+8 back to 0x20; x0 still strobed
    fetch(32'h18, 32'h0080006F);
    @(negedge Clk);
    chk("jal0_rdw", {26'd0, Rd_id, Rd_write}, {26'd0, 5'd0, 1'b1});
    chk("jal0_rd", Rd_data, 32'h1C);

    // BEQ not taken
    fetch(32'h20, 32'hFE208CE3);
    @(negedge Clk);
    // Unknown opcode at 0x24 falls through
    fetch(32'h24, 32'h0000_0000);
    chk("nop_quiet", {29'd0, Rd_write, Alu_enable, M_wb_cs}, 32'd0);
    // JAL x0,+0x18 to 0x40
    fetch(32'h28, 32'h0180006F);
    @(negedge Clk);

    // LW x5,0(x0) with Irq raised mid-transfer
    fetch(32'h40, 32'h00002283);
    @(negedge Clk);
    Irq = 1'b1;
    chk("irq_l_cs1", {31'd0, M_wb_cs}, 32'd1);
    @(negedge Clk);
    chk("irq_l_wait", {30'd0, M_wb_cs, Irq_ack}, 32'd2);
    @(negedge Clk);
    M_wb_rdata = 32'hDEAD_BEEF; M_wb_ack = 1'b1;
    #1;
    chk("irq_l_data", Rd_data, 32'hDEAD_BEEF);
    chk("irq_l_rdw", {31'd0, Rd_write}, 32'd1);
    @(negedge Clk);
    M_wb_ack = 1'b0; M_wb_rdata = '0;
    chk("irq_ack", {30'd0, Irq_ack, M_wb_cs}, 32'd2);
    chk("irq_epc", Epc, 32'h44);
    Irq = 1'b0;
    // Handler: SH x3,1(x0) is misaligned
    fetch(32'h10, 32'h003010A3);
    chk("irq_ack_1cyc", {31'd0, Irq_ack}, 32'd0);
    @(negedge Clk);
    chk("mis_no_cs", {31'd0, M_wb_cs}, 32'd0);
    @(negedge Clk);
    chk("mis_fault", {30'd0, Fault, M_wb_cs}, 32'd2);
    repeat (3) @(negedge Clk);
    chk("fault_sticky", {29'd0, Fault, M_wb_cs, Rd_write}, 32'd4);

    // Async reset clears Fault
    #2 Rst_n = 1'b0;
    #1 chk("arst_fault", {31'd0, Fault}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("restart", {M_wb_addr[30:0], M_wb_cs}, 32'd1);
    // Reset mid-fetch drops cs at once
    #2 Rst_n = 1'b0;
    #1 chk("arst_cs", {31'd0, M_wb_cs}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Fetch never acked
    n = 0;
    @(negedge Clk);
    while (M_wb_cs && n < 40) begin
      n++;
      @(negedge Clk);
    end
    chk("timeout_cycles", n, 32'd15);
    chk("timeout_fault", {31'd0, Fault}, 32'd1);

    Rst_n = 1'b0;
    #1 chk("final_rst", {31'd0, Fault}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    fetch(32'h0, 32'h00500093);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
